// File: rtl/sha3_pkg.sv
// Shared constants, padding bytes and FSM state type for the SHA3 rate-block pad buffer.
// Define SHA3_KECCAK_LEGACY_EN to select original Keccak padding (domain byte 0x01).
package sha3_pkg;

    localparam int RATE_BITS  = 576;
    localparam int RATE_WORDS = 9;
    localparam int RATE_BYTES = 72;
    localparam int LANE_W     = 64;

`ifdef SHA3_KECCAK_LEGACY_EN
    localparam logic [7:0] SHA3_DOMAIN_BYTE = 8'h01;
`else
    localparam logic [7:0] SHA3_DOMAIN_BYTE = 8'h06;
`endif
    localparam logic [7:0] SHA3_PAD_END = 8'h80;

    // Block emitted when the message ended exactly on a rate boundary.
    localparam logic [RATE_BITS-1:0] PAD_ONLY_BLOCK =
        {SHA3_PAD_END, {(RATE_BITS-16){1'b0}}, SHA3_DOMAIN_BYTE};

    typedef enum logic [1:0] {
        FILL     = 2'd0,
        HOLD     = 2'd1,
        PAD_ONLY = 2'd2
    } pad_state_t;

    function automatic logic [3:0] clamp_bytes(input logic [3:0] nb);
        if (nb > 4'd8) begin
            clamp_bytes = 4'd8;
        end else begin
            clamp_bytes = nb;
        end
    endfunction

endpackage

// File: rtl/sha3_pad_gen.sv
// Combinational final-word masking and pad-byte mask generation for one accepted word.
// Padding byte selection follows SHA3_KECCAK_LEGACY_EN through sha3_pkg.
module sha3_pad_gen
    import sha3_pkg::*;
(
    input  logic [3:0]           widx,
    input  logic [3:0]           in_bytes,
    input  logic                 in_last,
    input  logic [LANE_W-1:0]    word_in,
    output logic [LANE_W-1:0]    word_out,
    output logic [RATE_BITS-1:0] pad_mask,
    output logic                 pad_pend
);

    logic [3:0] nb_s;
    logic [6:0] pos_s;

    // Byte masking of the last word and placement of domain/end pad bytes at byte pos_s.
    always_comb begin
        nb_s     = clamp_bytes(in_bytes);
        pos_s    = {widx, 3'b000} + {3'b000, nb_s};
        word_out = word_in;
        pad_mask = '0;
        pad_pend = 1'b0;
        if (in_last) begin
            for (int j = 0; j < 8; j++) begin
                if (4'(j) >= nb_s) begin
                    word_out[8*j +: 8] = 8'h00;
                end else begin
                    word_out[8*j +: 8] = word_in[8*j +: 8];
                end
            end
            // A full final word fills the block; padding goes into an extra block.
            if (pos_s == 7'(RATE_BYTES)) begin
                pad_pend = 1'b1;
            end else begin
                for (int b = 0; b < RATE_BYTES; b++) begin
                    if (pos_s == 7'(b)) begin
                        pad_mask[8*b +: 8] = SHA3_DOMAIN_BYTE;
                    end else begin
                        pad_mask[8*b +: 8] = 8'h00;
                    end
                end
                pad_mask[RATE_BITS-1 -: 8] = pad_mask[RATE_BITS-1 -: 8] | SHA3_PAD_END;
            end
        end else begin
            pad_pend = 1'b0;
        end
    end

endmodule

// File: rtl/sha3_pad_buffer.sv
// Collects 64-bit message words into 576-bit SHA3 rate blocks and pads the final block.
// Define SHA3_KECCAK_LEGACY_EN for original Keccak domain padding.
module sha3_pad_buffer #(
    parameter int RATE_BITS = 576,
    parameter int WORD_W    = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WORD_W-1:0]    in_data,
    input  logic                 in_last,
    input  logic [3:0]           in_bytes,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [RATE_BITS-1:0] blk_data,
    output logic                 blk_last
);
    import sha3_pkg::*;

    pad_state_t           state_q, state_d;
    logic [3:0]           widx_q, widx_d;
    logic                 pad_pend_q, pad_pend_d;
    logic [RATE_BITS-1:0] buf_q, buf_d;
    logic                 blk_valid_q, blk_valid_d;
    logic                 blk_last_q, blk_last_d;

    logic [WORD_W-1:0]    gen_word_s;
    logic [RATE_BITS-1:0] gen_mask_s;
    logic                 gen_pend_s;

    sha3_pad_gen u_pad_gen (
        .widx     (widx_q),
        .in_bytes (in_bytes),
        .in_last  (in_last),
        .word_in  (in_data),
        .word_out (gen_word_s),
        .pad_mask (gen_mask_s),
        .pad_pend (gen_pend_s)
    );

    // Next-state, buffer update and output decode.
    always_comb begin
        state_d     = state_q;
        widx_d      = widx_q;
        pad_pend_d  = pad_pend_q;
        buf_d       = buf_q;
        blk_valid_d = blk_valid_q;
        blk_last_d  = blk_last_q;
        in_ready    = 1'b0;
        case (state_q)
            FILL: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    for (int k = 0; k < RATE_WORDS; k++) begin
                        if (widx_q == 4'(k)) begin
                            buf_d[k*WORD_W +: WORD_W] = gen_word_s;
                        end else begin
                            buf_d[k*WORD_W +: WORD_W] = buf_q[k*WORD_W +: WORD_W];
                        end
                    end
                    if (in_last) begin
                        buf_d       = buf_d | gen_mask_s;
                        state_d     = HOLD;
                        blk_valid_d = 1'b1;
                        blk_last_d  = ~gen_pend_s;
                        pad_pend_d  = gen_pend_s;
                    end else if (widx_q == 4'(RATE_WORDS - 1)) begin
                        state_d     = HOLD;
                        blk_valid_d = 1'b1;
                        blk_last_d  = 1'b0;
                    end else begin
                        widx_d = widx_q + 4'd1;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            HOLD: begin
                if (blk_ready) begin
                    buf_d       = '0;
                    widx_d      = 4'd0;
                    blk_valid_d = 1'b0;
                    blk_last_d  = 1'b0;
                    state_d     = pad_pend_q ? PAD_ONLY : FILL;
                end else begin
                    state_d = HOLD;
                end
            end
            PAD_ONLY: begin
                buf_d       = PAD_ONLY_BLOCK;
                blk_last_d  = 1'b1;
                blk_valid_d = 1'b1;
                pad_pend_d  = 1'b0;
                state_d     = HOLD;
            end
            default: begin
                state_d     = FILL;
                widx_d      = 4'd0;
                pad_pend_d  = 1'b0;
                buf_d       = '0;
                blk_valid_d = 1'b0;
                blk_last_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset discards any partial message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FILL;
            widx_q      <= 4'd0;
            pad_pend_q  <= 1'b0;
            buf_q       <= '0;
            blk_valid_q <= 1'b0;
            blk_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            widx_q      <= widx_d;
            pad_pend_q  <= pad_pend_d;
            buf_q       <= buf_d;
            blk_valid_q <= blk_valid_d;
            blk_last_q  <= blk_last_d;
        end
    end

    assign blk_valid = blk_valid_q;
    assign blk_last  = blk_last_q;
    assign blk_data  = buf_q;

endmodule

// File: tb/tb_sha3_pad_buffer.sv
// Directed self-checking bench for sha3_pad_buffer with hand-computed padded blocks.
module tb_sha3_pad_buffer;

`ifdef SHA3_KECCAK_LEGACY_EN
    localparam logic [7:0] DOM = 8'h01;
`else
    localparam logic [7:0] DOM = 8'h06;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic [3:0]   in_bytes;
    logic         blk_valid;
    logic         blk_ready;
    logic [575:0] blk_data;
    logic         blk_last;

    int n_vec = 0;
    int n_err = 0;

    logic [575:0] exp_blk;

    sha3_pad_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_bytes  (in_bytes),
        .blk_valid (blk_valid),
        .blk_ready (blk_ready),
        .blk_data  (blk_data),
        .blk_last  (blk_last)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [575:0] obs, input logic [575:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] wpat(input int k);
        return 64'h1111_1111_1111_1111 * 64'(k + 1);
    endfunction

    task automatic send(input logic [63:0] w, input logic last, input logic [3:0] nb);
        @(negedge clk);
        check_vec("in_ready", 576'(in_ready), 576'(1'b1));
        in_valid = 1'b1;
        in_data  = w;
        in_last  = last;
        in_bytes = nb;
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 4'd0;
    endtask

    task automatic take_block(input string tag, input logic [575:0] exp, input logic exp_last,
                              input int exp_lat);
        int cyc = 0;
        while (!blk_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check_vec({tag, "_valid"}, 576'(blk_valid), 576'(1'b1));
        check_vec({tag, "_latency"}, 576'(cyc), 576'(exp_lat));
        check_vec({tag, "_data"}, blk_data, exp);
        check_vec({tag, "_last"}, 576'(blk_last), 576'(exp_last));
        blk_ready = 1'b1;
        @(negedge clk);
        blk_ready = 1'b0;
        check_vec({tag, "_drop"}, 576'(blk_valid), 576'(1'b0));
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = 64'd0;
        in_last   = 1'b0;
        in_bytes  = 4'd0;
        blk_ready = 1'b0;
        #12;
        check_vec("rst_valid", 576'(blk_valid), 576'(1'b0));
        check_vec("rst_last", 576'(blk_last), 576'(1'b0));
        check_vec("rst_data", blk_data, 576'd0);
        @(negedge clk);
        rst = 1'b0;

        // Empty message
        send(64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd0);
        exp_blk = '0;
        exp_blk[7:0] = DOM;
        exp_blk[575:568] = 8'h80;
        take_block("empty", exp_blk, 1'b1, 0);

        // "abc" with junk in the unused upper bytes
        send(64'hFFFF_FFFF_FF63_6261, 1'b1, 4'd3);
        exp_blk = '0;
        exp_blk[31:0] = {DOM, 24'h636261};
        exp_blk[575:568] = 8'h80;
        take_block("abc", exp_blk, 1'b1, 0);

        // 71-byte message: domain and end byte share byte 71
        for (int k = 0; k < 8; k++) send(wpat(k), 1'b0, 4'd0);
        send(64'hEE77_6655_4433_2211, 1'b1, 4'd7);
        exp_blk = '0;
        for (int k = 0; k < 8; k++) exp_blk[64*k +: 64] = wpat(k);
        exp_blk[575:512] = {DOM | 8'h80, 56'h77_6655_4433_2211};
        take_block("len71", exp_blk, 1'b1, 0);

        // 72-byte message: data block then padding-only block
        for (int k = 0; k < 8; k++) send(wpat(k), 1'b0, 4'd0);
        send(wpat(8), 1'b1, 4'd8);
        exp_blk = '0;
        for (int k = 0; k < 9; k++) exp_blk[64*k +: 64] = wpat(k);
        take_block("len72_data", exp_blk, 1'b0, 0);
        exp_blk = '0;
        exp_blk[7:0] = DOM;
        exp_blk[575:568] = 8'h80;
        take_block("len72_pad", exp_blk, 1'b1, 1);

        // in_bytes above 8 behaves as 8
        send(64'hDEAD_BEEF_0123_4567, 1'b1, 4'd12);
        exp_blk = '0;
        exp_blk[63:0] = 64'hDEAD_BEEF_0123_4567;
        exp_blk[71:64] = DOM;
        exp_blk[575:568] = 8'h80;
        take_block("nb12", exp_blk, 1'b1, 0);

        // Backpressure: 20 stalled cycles with input offered
        for (int k = 0; k < 9; k++) send(wpat(k + 3), 1'b0, 4'd0);
        exp_blk = '0;
        for (int k = 0; k < 9; k++) exp_blk[64*k +: 64] = wpat(k + 3);
        in_valid = 1'b1;
        in_data  = 64'hBAD0_BAD0_BAD0_BAD0;
        in_last  = 1'b1;
        in_bytes = 4'd8;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check_vec("bp_ready", 576'(in_ready), 576'(1'b0));
            check_vec("bp_valid", 576'(blk_valid), 576'(1'b1));
            check_vec("bp_data", blk_data, exp_blk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_bytes = 4'd0;
        take_block("bp_blk", exp_blk, 1'b0, 0);
        send(64'h0123_4567_89AB_CDEF, 1'b0, 4'd0);
        send(64'hFEDC_BA98_7654_3210, 1'b1, 4'd8);
        exp_blk = '0;
        exp_blk[63:0] = 64'h0123_4567_89AB_CDEF;
        exp_blk[127:64] = 64'hFEDC_BA98_7654_3210;
        exp_blk[135:128] = DOM;
        exp_blk[575:568] = 8'h80;
        take_block("bp_next", exp_blk, 1'b1, 0);

        // Reset in the middle of a message
        for (int k = 0; k < 5; k++) send(wpat(k), 1'b0, 4'd0);
        #2;
        rst = 1'b1;
        #1;
        check_vec("mid_rst_valid", 576'(blk_valid), 576'(1'b0));
        check_vec("mid_rst_data", blk_data, 576'd0);
        @(negedge clk);
        rst = 1'b0;
        send(64'h0000_0000_0063_6261, 1'b1, 4'd3);
        exp_blk = '0;
        exp_blk[31:0] = {DOM, 24'h636261};
        exp_blk[575:568] = 8'h80;
        take_block("post_rst", exp_blk, 1'b1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/sha3_pad_buffer.md
# sha3_pad_buffer

Upstream feeder of the absorb XOR stage. Collects 64-bit message words into a 576-bit rate block (SHA3-512 rate, 9 words) and applies SHA3 multi-rate padding to the final block. Presents each complete block, with a last-block flag, on a valid/ready handshake. The absorb stage consumes each block as its `data_in`.

## Interface
- `RATE_BITS`, 576: rate block width; must be a multiple of `WORD_W`.
- `WORD_W`, 64: input word width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: input word valid.
- `in_ready` out 1: buffer accepts a word this cycle.
- `in_data` in WORD_W: message word, little-endian; byte 0 is `in_data[7:0]`.
- `in_last` in 1: this word ends the message.
- `in_bytes` in 4: valid bytes in the last word, 0..8; ignored unless `in_last`; values 9..15 are treated as 8.
- `blk_valid` out 1: output block valid.
- `blk_ready` in 1: downstream accepts the block.
- `blk_data` out RATE_BITS: rate block; word k occupies bits [64k+63:64k].
- `blk_last` out 1: block is the final, padded block of the message.

## Operation
- States:
  - FILL: accept words.
  - HOLD: present the block.
  - PAD_ONLY: build a padding-only block.
- FILL:
  - `in_ready`=1.
  - Word index `widx` counts 0..8.
  - On accept without `in_last`: store the word at `widx`; if `widx`=8, go to HOLD with `blk_last`=0; else increment `widx`.
- Accept with `in_last`:
  - Store the valid bytes of the word.
  - Zero invalid bytes and all higher words.
  - Padding position p = 8·widx + in_bytes, which is the byte index within the block.
  - If p ≤ 71: byte p |= domain byte (0x06), byte 71 |= 0x80, then go to HOLD with `blk_last`=1.
  - If p = 71: byte 71 = 0x86.
  - If p = 72 (full final word at widx 8): go to HOLD with `blk_last`=0 and set `pad_pend`.
- HOLD:
  - `blk_valid`=1; `blk_data`/`blk_last` stable until the handshake.
  - On `blk_valid`&&`blk_ready`: clear the buffer and reset `widx` to 0.
  - Next state is PAD_ONLY if `pad_pend`, else FILL.
- PAD_ONLY:
  - Load byte 0 = 0x06, byte 71 = 0x80, all other bytes 0.
  - Set `blk_last`=1, clear `pad_pend`, go to HOLD. Takes 1 cycle.
- Empty message (`in_last`, `in_bytes`=0, `widx`=0) produces one block: byte 0 = 0x06, byte 71 = 0x80.
- `in_ready`=0 in HOLD and PAD_ONLY; no input overlap.
- Reset, at any time:
  - state = FILL, `widx` = 0, `pad_pend` = 0, buffer = 0.
  - `blk_valid` = 0, `blk_last` = 0, `in_ready` = 1 after reset release.
  - A partially collected message is discarded.

## Timing
- All outputs are registered except `in_ready`, which is decoded from state.
- `blk_valid` rises on the cycle after the 9th word or the last word is accepted.
- Minimum throughput:
  - 9 accept cycles + 1 HOLD cycle = 10 cycles per block when `blk_ready` is held high.
  - Extra-pad case adds 1 PAD_ONLY cycle + 1 HOLD cycle.
- `blk_ready` asserted before `blk_valid` is legal; the handshake completes on the first cycle both are high.
- Protocol rules:
  - `blk_valid` never drops without a handshake (AXI-style).
  - `in_data`/`in_last`/`in_bytes` are sampled only when `in_valid`&&`in_ready`.

## Configuration
- `SHA3_KECCAK_LEGACY_EN`:
  - Defined: domain byte 0x01 (original Keccak padding); boundary byte at p=71 becomes 0x81.
  - Undefined (default): domain byte 0x06, FIPS 202 SHA3.
  - No other behaviour changes.

## Structure
- Package `sha3_pkg`:
  - `RATE_BITS`, `RATE_WORDS`=9, `RATE_BYTES`=72.
  - `SHA3_DOMAIN_BYTE` (selected by the macro), `SHA3_PAD_END`=0x80.
  - State enum `pad_state_t` {FILL, HOLD, PAD_ONLY}.
- Sub-module `sha3_pad_gen`, combinational: given word index, `in_bytes`, and the word, returns the masked word plus a 576-bit pad-OR mask.

## Test plan
- Empty message: one word with `in_last`, `in_bytes`=0 → one block with byte0=0x06, byte71=0x80, rest 0, `blk_last`=1.
- Message "abc" (`in_data`=0x636261, `in_bytes`=3) → bytes 0..2 = 61 62 63, byte3=0x06, byte71=0x80, `blk_last`=1.
- 71-byte message (8 full words, then a last word with `in_bytes`=7) → byte71=0x86, single block, `blk_last`=1.
- 72-byte message (9 full words, `in_last` on word 8 with `in_bytes`=8):
  - Block 1 = data with `blk_last`=0.
  - Block 2 = byte0 0x06, byte71 0x80, `blk_last`=1.
- Backpressure: hold `blk_ready`=0 for 20 cycles in HOLD → `blk_data` stable, `in_ready`=0, no words lost; next message's first word lands at word 0.
- Assert `rst` after 5 words accepted → `blk_valid`=0 immediately; a new message after release produces a block containing no stale data.
